led_blink_consumer: RTL and testbench

Consumer end of the slow blink clock. Takes the free-running blink square wave plus per-LED mode selects and activity pulses, and drives board LEDs. Activity pulses are stretched and synchronised to blink edges so that single-cycle events become visible. Sits between datapath status (link/activity strobes) and the board LED pins.

---
 rtl/led_blink_consumer.sv | 138 +++++++++++++
 tb/tb_led_blink_consumer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_consumer.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_consumer
// Purpose  : Drives board LEDs from per-LED mode selects; activity strobes are
//            stretched into blink-aligned flashes. Optional: LED_ACTIVE_LOW_EN.
// Revision : 1.0  initial release
// ============================================================================
module led_blink_consumer #(
    parameter int NUM_LEDS  = 4,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 1,
    parameter int CNT_W     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  blink,
    input  logic [2*NUM_LEDS-1:0] mode,
    input  logic [NUM_LEDS-1:0]   activity,
    output logic [NUM_LEDS-1:0]   led
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHOW  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [1:0] c_MODE_OFF   = 2'b00;
    localparam logic [1:0] c_MODE_ON    = 2'b01;
    localparam logic [1:0] c_MODE_BLINK = 2'b10;

    localparam logic [CNT_W-1:0] c_ON_LOAD  = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] c_OFF_LOAD = CNT_W'((OFF_TICKS > 0) ? OFF_TICKS - 1 : 0);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

`ifdef LED_ACTIVE_LOW_EN
    localparam logic c_POL = 1'b1;
`else
    localparam logic c_POL = 1'b0;
`endif

    logic                  r_blink_q;
    logic [2*NUM_LEDS-1:0] r_mode;
    logic                  w_tick;

    assign w_tick = blink & ~r_blink_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_q <= 1'b0;
            r_mode    <= '0;
        end else begin
            r_blink_q <= blink;
            r_mode    <= mode;
        end
    end

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
        logic [1:0]       w_mode;
        logic             w_changed;
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_pend;
        logic             r_led;

        assign w_mode    = mode[2*gi +: 2];
        assign w_changed = (w_mode != r_mode[2*gi +: 2]);
        assign led[gi]   = r_led;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_pend  <= 1'b0;
                r_led   <= c_POL;
            end else begin
                case (w_mode)
                    c_MODE_OFF:   r_led <= c_POL;
                    c_MODE_ON:    r_led <= ~c_POL;
                    c_MODE_BLINK: r_led <= r_blink_q ^ c_POL;
                    default:      r_led <= ((r_state == ST_SHOW) && !w_changed) ^ c_POL;
                endcase

                // Any mode other than a steady activity mode parks the FSM.
                if (w_changed || (w_mode != 2'b11)) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_pend  <= 1'b0;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (activity[gi] || r_pend) begin
                                r_state <= ST_ARMED;
                                r_pend  <= 1'b0;
                            end
                        end
                        ST_ARMED: begin
                            if (w_tick) begin
                                r_state <= ST_SHOW;
                                r_cnt   <= c_ON_LOAD;
                            end
                        end
                        ST_SHOW: begin
                            if (w_tick) begin
                                if (r_cnt == '0) begin
                                    if (OFF_TICKS > 0) begin
                                        r_state <= ST_GAP;
                                        r_cnt   <= c_OFF_LOAD;
                                    end else begin
                                        r_state <= ST_IDLE;
                                    end
                                end else begin
                                    r_cnt <= r_cnt - c_CNT_ONE;
                                end
                            end
                        end
                        ST_GAP: begin
                            if (activity[gi]) begin
                                r_pend <= 1'b1;
                            end
                            if (w_tick) begin
                                if (r_cnt == '0) begin
                                    r_state <= ST_IDLE;
                                end else begin
                                    r_cnt <= r_cnt - c_CNT_ONE;
                                end
                            end
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_blink_consumer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_blink_consumer
// Purpose  : Directed bench for led_blink_consumer with a tick-ordinal model.
// Revision : 1.0  initial release
// ============================================================================
module tb_led_blink_consumer;

    localparam int N   = 4;
    localparam int ON  = 2;
    localparam int OFF = 1;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [N-1:0] c_POLV = 4'b1111;
`else
    localparam logic [N-1:0] c_POLV = 4'b0000;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         blink;
    logic [7:0]   mode;
    logic [N-1:0] activity;
    logic [N-1:0] led;

    int tests = 0;
    int fails = 0;

    led_blink_consumer #(
        .NUM_LEDS (N),
        .ON_TICKS (ON),
        .OFF_TICKS(OFF),
        .CNT_W    (4)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .blink   (blink),
        .mode    (mode),
        .activity(activity),
        .led     (led)
    );

    always #5 clk = ~clk;

    // Model: a flash is described by the ordinal of the tick that starts it.
    bit           m_valid = 1'b0;
    bit           m_busy  [N];
    int           m_start [N];
    bit           m_pend  [N];
    int           m_k;
    logic         m_prev_blink;
    logic [7:0]   m_prev_mode;
    logic [N-1:0] exp_led;

    always @(posedge clk) begin
        int       tk;
        logic [1:0] md;
        bit       chg, show, gap, idle;
        logic     e;
        if (reset) begin
            m_valid      = 1'b1;
            m_k          = 0;
            m_prev_blink = 1'b0;
            m_prev_mode  = 8'h00;
            exp_led      = c_POLV;
            for (int c = 0; c < N; c++) begin
                m_busy[c] = 1'b0; m_pend[c] = 1'b0; m_start[c] = 0;
            end
        end else if (m_valid) begin
            tk = (blink && !m_prev_blink) ? 1 : 0;
            for (int c = 0; c < N; c++) begin
                md   = mode[2*c +: 2];
                chg  = (md != m_prev_mode[2*c +: 2]);
                show = m_busy[c] && (m_start[c] <= m_k) && (m_k < m_start[c] + ON);
                gap  = m_busy[c] && (m_start[c] + ON <= m_k) && (m_k < m_start[c] + ON + OFF);
                idle = !m_busy[c] || (m_k >= m_start[c] + ON + OFF);
                case (md)
                    2'b00:   e = 1'b0;
                    2'b01:   e = 1'b1;
                    2'b10:   e = m_prev_blink;
                    default: e = !chg && show;
                endcase
                exp_led[c] = e ^ c_POLV[c];
                if (md != 2'b11 || chg) begin
                    m_busy[c] = 1'b0; m_pend[c] = 1'b0;
                end else if (idle) begin
                    if (activity[c] || m_pend[c]) begin
                        m_busy[c]  = 1'b1;
                        m_start[c] = m_k + tk + 1;
                        m_pend[c]  = 1'b0;
                    end else begin
                        m_busy[c] = 1'b0;
                    end
                end else if (gap && activity[c]) begin
                    m_pend[c] = 1'b1;
                end
            end
            m_k          = m_k + tk;
            m_prev_blink = blink;
            m_prev_mode  = mode;
        end
    end

    // Per-cycle model comparison plus lit/rise counters for directed checks.
    int           on_cnt   [N];
    int           rise_cnt [N];
    logic [N-1:0] prev_lit = '0;

    always @(negedge clk) begin
        logic [N-1:0] lit;
        if (m_valid) begin
            tests++;
            if (led !== exp_led) begin
                fails++;
                $display("FAIL model t=%0t led=%b expected=%b", $time, led, exp_led);
            end
            lit = led ^ c_POLV;
            for (int c = 0; c < N; c++) begin
                if (lit[c]) on_cnt[c]++;
                if (lit[c] && !prev_lit[c]) rise_cnt[c]++;
            end
            prev_lit = lit;
        end
    end

    task automatic check(input string name, input int got, input int expv);
        tests++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d", name, got, expv);
        end
    endtask

    function automatic logic [N-1:0] lit_now();
        return led ^ c_POLV;
    endfunction

    int half = 8;
    int bph  = 0;
    bit brun = 1'b0;
    bit rose = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
        rose = 1'b0;
        if (brun) begin
            bph++;
            if (bph >= half) begin
                bph   = 0;
                blink = ~blink;
                rose  = blink;
            end
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic to_rise();
        int n = 0;
        rose = 1'b0;
        while (!rose && n < 64) begin
            step();
            n++;
        end
        if (!rose) begin
            tests++;
            fails++;
            $display("FAIL blink_rise_timeout got=0 expected=1");
        end
    endtask

    task automatic pulse(input int ch);
        activity[ch] = 1'b1;
        step();
        activity[ch] = 1'b0;
    endtask

    task automatic clr_mon();
        for (int c = 0; c < N; c++) begin
            on_cnt[c] = 0; rise_cnt[c] = 0;
        end
    endtask

    initial begin
        reset = 1'b1; blink = 1'b0; mode = 8'h00; activity = '0;
        clr_mon();
        steps(3);
        reset = 1'b0;
        step();
        check("reset_led", int'(lit_now()), 0);

        mode = 8'h55;
        check("on_before_edge", int'(lit_now()), 0);
        step();
        check("on_one_clk", int'(lit_now()), 4'hF);

        // Blink mode, toggle every 16 clk
        half = 16; bph = 0; brun = 1'b1; mode = 8'hAA;
        steps(4);
        clr_mon();
        repeat (96) begin
            step();
            check("blink_same", int'(lit_now() == 4'h0 || lit_now() == 4'hF), 1);
        end
        check("blink_duty0", on_cnt[0], 48);
        check("blink_duty3", on_cnt[3], 48);

        // Activity mode, blink period 16 clk
        brun = 1'b0; blink = 1'b0; mode = 8'hFF;
        steps(4);
        half = 8; bph = 0; brun = 1'b1;
        to_rise(); steps(4);
        clr_mon();
        pulse(0);
        steps(100);
        check("flash0_len", on_cnt[0], 32);
        check("flash0_count", rise_cnt[0], 1);
        check("flash_others_dark", on_cnt[1] + on_cnt[2] + on_cnt[3], 0);

        // Pending collapse on channel 1
        to_rise(); steps(4);
        clr_mon();
        pulse(1);
        to_rise(); to_rise(); to_rise();
        steps(3);
        repeat (3) begin
            pulse(1);
            step();
        end
        steps(150);
        check("pend_flashes", rise_cnt[1], 2);
        check("pend_lit", on_cnt[1], 64);

        // Mode change mid-flash on channel 2
        to_rise(); steps(4);
        pulse(2);
        to_rise(); steps(4);
        check("flash2_lit", int'(lit_now() >> 2) & 1, 1);
        mode = 8'hCF;
        step();
        check("mode_off_dark", int'(lit_now() >> 2) & 1, 0);
        mode = 8'hFF;
        step();
        check("mode_back_dark", int'(lit_now() >> 2) & 1, 0);
        clr_mon();
        steps(80);
        check("mode_back_noflash", on_cnt[2], 0);

        // Reset mid-SHOW on channel 3
        to_rise(); steps(4);
        pulse(3);
        to_rise(); steps(4);
        check("flash3_lit", int'(lit_now() >> 3) & 1, 1);
        reset = 1'b1;
        step();
        check("reset_mid_show", int'(lit_now()), 0);
        reset = 1'b0;
        clr_mon();
        steps(80);
        check("reset_noresidual", on_cnt[3], 0);

        // Static blink: channel waits armed until the first rise
        brun = 1'b0; blink = 1'b0;
        steps(2);
        pulse(3);
        clr_mon();
        steps(200);
        check("static_dark", on_cnt[3], 0);
        blink = 1'b1;
        step();
        check("first_rise_pre", int'(lit_now() >> 3) & 1, 0);
        step();
        check("first_rise_lit", int'(lit_now() >> 3) & 1, 1);
        steps(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
